// File: rtl/uart_inst_loader.sv
// UART boot loader: receives an A5 / length / little-endian word image, writes it into instruction
// memory and holds the core in reset until the load completes. Define UART_LOADER_CHECKSUM_EN for a trailing XOR check byte.
module uart_inst_loader #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int ADDR_W   = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [31:0]       im_wdata,
  output logic              core_rst_n,
  output logic              boot_done,
  output logic              boot_err
);
  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = $clog2(DIV) + 1;
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DIV - 1);
  localparam logic [16:0]      CAPACITY = 17'd1 << ADDR_W;

  typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3} rx_state_t;
  typedef enum logic [2:0] {
    L_SYNC = 3'd0, L_LEN0 = 3'd1, L_LEN1 = 3'd2, L_DATA = 3'd3, L_DONE = 3'd4, L_ERR = 3'd5
`ifdef UART_LOADER_CHECKSUM_EN
    , L_CHK = 3'd6
`endif
  } ld_state_t;

`ifdef UART_LOADER_CHECKSUM_EN
  localparam ld_state_t L_AFTER = L_CHK;
`else
  localparam ld_state_t L_AFTER = L_DONE;
`endif

  rx_state_t        rx_state_r, rx_next_s;
  logic             rx_meta_r, rx_sync_r;
  logic [CNT_W-1:0] baud_cnt_r;
  logic [2:0]       bit_cnt_r;
  logic [7:0]       shift_r;
  logic             byte_vld_r, frame_err_r, tick_s;

  ld_state_t        ld_state_r, ld_next_s;
  logic [7:0]       len_lo_r;
  logic [15:0]      len_r, len_s;
  logic [16:0]      word_cnt_r;
  logic [1:0]       byte_idx_r;
  logic             last_word_s;

  // Sample point: mid start bit in RX_START, one full bit period elsewhere.
  always_comb begin
    if (rx_state_r == RX_START) tick_s = (baud_cnt_r == HALF_CNT);
    else                        tick_s = (baud_cnt_r == FULL_CNT);
  end

  // RX next-state logic.
  always_comb begin
    rx_next_s = rx_state_r;
    case (rx_state_r)
      RX_IDLE:  if (!rx_sync_r) rx_next_s = RX_START; else rx_next_s = RX_IDLE;
      RX_START: if (tick_s) rx_next_s = rx_sync_r ? RX_IDLE : RX_DATA; else rx_next_s = RX_START;
      RX_DATA:  if (tick_s && (bit_cnt_r == 3'd7)) rx_next_s = RX_STOP; else rx_next_s = RX_DATA;
      RX_STOP:  if (tick_s) rx_next_s = RX_IDLE; else rx_next_s = RX_STOP;
      default:  rx_next_s = RX_IDLE;
    endcase
  end

  // RX synchronizer, state register, baud/bit counters and byte/framing pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_r   <= 1'b1;
      rx_sync_r   <= 1'b1;
      rx_state_r  <= RX_IDLE;
      baud_cnt_r  <= '0;
      bit_cnt_r   <= 3'd0;
      shift_r     <= 8'd0;
      byte_vld_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      rx_meta_r   <= uart_rx;
      rx_sync_r   <= rx_meta_r;
      rx_state_r  <= rx_next_s;
      byte_vld_r  <= 1'b0;
      frame_err_r <= 1'b0;
      if ((rx_state_r == RX_IDLE) || tick_s) baud_cnt_r <= '0;
      else                                   baud_cnt_r <= baud_cnt_r + CNT_W'(1);
      if (rx_state_r == RX_IDLE) bit_cnt_r <= 3'd0;
      if ((rx_state_r == RX_DATA) && tick_s) begin
        shift_r   <= {rx_sync_r, shift_r[7:1]};
        bit_cnt_r <= bit_cnt_r + 3'd1;
      end
      if ((rx_state_r == RX_STOP) && tick_s) begin
        byte_vld_r  <= rx_sync_r;
        frame_err_r <= ~rx_sync_r;
      end
    end
  end

  assign len_s       = {shift_r, len_lo_r};
  assign last_word_s = ((word_cnt_r + 17'd1) == {1'b0, len_r});

`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0] csum_r;

  // Running XOR of every payload byte.
  always_ff @(posedge clk) begin
    if (!rst_n) csum_r <= 8'd0;
    else if (byte_vld_r && (ld_state_r == L_DATA)) csum_r <= csum_r ^ shift_r;
    else csum_r <= csum_r;
  end
`endif

  // Loader next-state logic; once finished or failed only rst_n leaves.
  always_comb begin
    ld_next_s = ld_state_r;
    case (ld_state_r)
      L_SYNC: begin
        if (byte_vld_r && (shift_r == 8'hA5)) ld_next_s = L_LEN0;
        else                                  ld_next_s = L_SYNC;
      end
      L_LEN0: begin
        if (frame_err_r)     ld_next_s = L_ERR;
        else if (byte_vld_r) ld_next_s = L_LEN1;
        else                 ld_next_s = L_LEN0;
      end
      L_LEN1: begin
        if (frame_err_r) ld_next_s = L_ERR;
        else if (byte_vld_r) begin
          if (len_s == 16'd0)                   ld_next_s = L_AFTER;
          else if ({1'b0, len_s} > CAPACITY)    ld_next_s = L_ERR;
          else                                  ld_next_s = L_DATA;
        end else ld_next_s = L_LEN1;
      end
      L_DATA: begin
        if (frame_err_r) ld_next_s = L_ERR;
        else if (byte_vld_r && (byte_idx_r == 2'd3) && last_word_s) ld_next_s = L_AFTER;
        else ld_next_s = L_DATA;
      end
`ifdef UART_LOADER_CHECKSUM_EN
      L_CHK: begin
        if (frame_err_r)     ld_next_s = L_ERR;
        else if (byte_vld_r) ld_next_s = (shift_r == csum_r) ? L_DONE : L_ERR;
        else                 ld_next_s = L_CHK;
      end
`endif
      L_DONE:  ld_next_s = L_DONE;
      L_ERR:   ld_next_s = L_ERR;
      default: ld_next_s = L_ERR;
    endcase
  end

  // Loader state register, word assembly, write strobe and sticky status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_state_r <= L_SYNC;
      len_lo_r   <= 8'd0;
      len_r      <= 16'd0;
      word_cnt_r <= 17'd0;
      byte_idx_r <= 2'd0;
      im_we      <= 1'b0;
      im_waddr   <= '0;
      im_wdata   <= 32'd0;
      core_rst_n <= 1'b0;
      boot_done  <= 1'b0;
      boot_err   <= 1'b0;
    end else begin
      ld_state_r <= ld_next_s;
      im_we      <= 1'b0;
      if (byte_vld_r && (ld_state_r == L_LEN0)) len_lo_r <= shift_r;
      if (byte_vld_r && (ld_state_r == L_LEN1)) len_r <= len_s;
      if (byte_vld_r && (ld_state_r == L_DATA)) begin
        im_wdata[{byte_idx_r, 3'b000} +: 8] <= shift_r;
        byte_idx_r <= byte_idx_r + 2'd1;
        if (byte_idx_r == 2'd3) begin
          im_we      <= 1'b1;
          word_cnt_r <= word_cnt_r + 17'd1;
        end
      end
      // The last word moves the FSM out of L_DATA, so the address never steps past N-1.
      if (im_we && (ld_state_r == L_DATA)) im_waddr <= im_waddr + ADDR_W'(1);
      if (ld_state_r == L_DONE) begin
        core_rst_n <= 1'b1;
        boot_done  <= 1'b1;
      end
      if (ld_state_r == L_ERR) boot_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_inst_loader.sv
// Self-checking bench for uart_inst_loader: drives 8N1 frames and checks the observed memory writes
// against the word list each image was built from.
module tb_uart_inst_loader;
  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 100000;
  localparam int ADDR_W   = 12;
  localparam int DIV      = CLK_FREQ / BAUD;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              uart_rx = 1'b1;
  logic              im_we;
  logic [ADDR_W-1:0] im_waddr;
  logic [31:0]       im_wdata;
  logic              core_rst_n, boot_done, boot_err;

  uart_inst_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .im_we(im_we), .im_waddr(im_waddr),
    .im_wdata(im_wdata), .core_rst_n(core_rst_n), .boot_done(boot_done), .boot_err(boot_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [ADDR_W-1:0] wa_q[$];
  logic [31:0]       wd_q[$];
  logic [31:0]       exp_words[$];
  int we_cyc = -1;
  int done_cyc = -1;
  int n_checks = 0;
  int n_err = 0;

  // Write monitor: log every strobe and the first cycle the core is released.
  always @(negedge clk) begin
    if (rst_n && im_we) begin
      wa_q.push_back(im_waddr);
      wd_q.push_back(im_wdata);
      we_cyc = cyc;
    end
    if (rst_n && core_rst_n && (done_cyc < 0)) done_cyc = cyc;
  end

  task do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
    wa_q.delete();
    wd_q.delete();
    we_cyc = -1;
    done_cyc = -1;
  endtask

  task send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (DIV) @(negedge clk);
    uart_rx = 1'b1;
    repeat (DIV) @(negedge clk);
  endtask

  task send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
  endtask

  // Trailing check byte (only with the checksum build): XOR of all payload bytes, optionally corrupted.
  task send_checksum(input logic corrupt);
`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0] c;
    logic [31:0] w;
    c = 8'd0;
    for (int i = 0; i < exp_words.size(); i++) begin
      w = exp_words[i];
      c = c ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    end
    send_byte(c ^ {7'd0, corrupt}, 1'b1);
`else
    if (corrupt) @(negedge clk);
`endif
  endtask

  task send_image(input logic [15:0] n);
    send_byte(8'hA5, 1'b1);
    send_byte(n[7:0], 1'b1);
    send_byte(n[15:8], 1'b1);
    for (int i = 0; i < exp_words.size(); i++) send_word(exp_words[i]);
    send_checksum(1'b0);
  endtask

  task wait_end(input string name);
    int k;
    k = 0;
    while (!(boot_done || boot_err) && (k < 4000)) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k >= 4000) begin
      n_err++;
      $display("FAIL %s_timeout: no boot_done/boot_err within %0d cycles", name, k);
    end
    repeat (3) @(negedge clk);
  endtask

  task test_reset;
    do_reset(2);
    n_checks++; if (im_we !== 1'b0)       begin n_err++; $display("FAIL reset_im_we: got %b want 0", im_we); end
    n_checks++; if (im_waddr !== '0)      begin n_err++; $display("FAIL reset_waddr: got %h want 0", im_waddr); end
    n_checks++; if (im_wdata !== 32'd0)   begin n_err++; $display("FAIL reset_wdata: got %h want 0", im_wdata); end
    n_checks++; if (core_rst_n !== 1'b0)  begin n_err++; $display("FAIL reset_core_rst_n: got %b want 0", core_rst_n); end
    n_checks++; if (boot_done !== 1'b0)   begin n_err++; $display("FAIL reset_boot_done: got %b want 0", boot_done); end
    n_checks++; if (boot_err !== 1'b0)    begin n_err++; $display("FAIL reset_boot_err: got %b want 0", boot_err); end
  endtask

  task test_spec_image;
    do_reset(2);
    exp_words.delete();
    exp_words.push_back(32'h00100513);
    exp_words.push_back(32'h0000006F);
    send_image(16'd2);
    wait_end("spec");
    n_checks++; if (wa_q.size() != 2) begin n_err++; $display("FAIL spec_count: got %0d want 2", wa_q.size()); end
    for (int i = 0; i < wa_q.size() && i < 2; i++) begin
      n_checks++; if (wa_q[i] !== ADDR_W'(i)) begin n_err++; $display("FAIL spec_addr%0d: got %h want %h", i, wa_q[i], i); end
      n_checks++; if (wd_q[i] !== exp_words[i]) begin n_err++; $display("FAIL spec_data%0d: got %h want %h", i, wd_q[i], exp_words[i]); end
    end
    n_checks++; if (done_cyc !== we_cyc + 1) begin n_err++; $display("FAIL spec_release: got cycle %0d want %0d", done_cyc, we_cyc + 1); end
    n_checks++; if ({boot_done, boot_err} !== 2'b10) begin n_err++; $display("FAIL spec_status: got %b want 10", {boot_done, boot_err}); end
  endtask

  task test_junk_zero_len;
    do_reset(2);
    exp_words.delete();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_image(16'd0);
    wait_end("zero");
    n_checks++; if (wa_q.size() != 0) begin n_err++; $display("FAIL zero_count: got %0d want 0", wa_q.size()); end
    n_checks++; if ({core_rst_n, boot_done, boot_err} !== 3'b110) begin n_err++; $display("FAIL zero_status: got %b want 110", {core_rst_n, boot_done, boot_err}); end
  endtask

  task test_random_images;
    int n, nj;
    logic [7:0] j;
    for (int it = 0; it < 3; it++) begin
      do_reset(2);
      exp_words.delete();
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) exp_words.push_back($urandom);
      nj = $urandom_range(0, 2);
      for (int i = 0; i < nj; i++) begin
        j = 8'($urandom_range(0, 255));
        if (j == 8'hA5) j = 8'h5A;
        send_byte(j, 1'b1);
      end
      send_image(16'(n));
      wait_end("rand");
      n_checks++; if (wa_q.size() != n) begin n_err++; $display("FAIL rand_count: got %0d want %0d", wa_q.size(), n); end
      for (int i = 0; i < wa_q.size() && i < n; i++) begin
        n_checks++; if (wa_q[i] !== ADDR_W'(i)) begin n_err++; $display("FAIL rand_addr%0d: got %h want %h", i, wa_q[i], i); end
        n_checks++; if (wd_q[i] !== exp_words[i]) begin n_err++; $display("FAIL rand_data%0d: got %h want %h", i, wd_q[i], exp_words[i]); end
      end
      n_checks++; if (done_cyc !== we_cyc + 1) begin n_err++; $display("FAIL rand_release: got cycle %0d want %0d", done_cyc, we_cyc + 1); end
      n_checks++; if ({boot_done, boot_err} !== 2'b10) begin n_err++; $display("FAIL rand_status: got %b want 10", {boot_done, boot_err}); end
    end
  endtask

  task test_framing_error;
    do_reset(2);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    wait_end("frame");
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b1);
    repeat (5) @(negedge clk);
    n_checks++; if (wa_q.size() != 0) begin n_err++; $display("FAIL frame_count: got %0d want 0", wa_q.size()); end
    n_checks++; if ({core_rst_n, boot_done, boot_err} !== 3'b001) begin n_err++; $display("FAIL frame_status: got %b want 001", {core_rst_n, boot_done, boot_err}); end
  endtask

  task test_glitch;
    logic [31:0] w;
    do_reset(2);
    exp_words.delete();
    w = $urandom;
    exp_words.push_back(w);
    for (int g = 0; g < 2; g++) begin
      @(negedge clk); uart_rx = 1'b0;
      repeat (2) @(negedge clk); uart_rx = 1'b1;
      repeat (3 * DIV) @(negedge clk);
      if (g == 0) begin
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(w[7:0], 1'b1);
        send_byte(w[15:8], 1'b1);
      end
    end
    send_byte(w[23:16], 1'b1);
    send_byte(w[31:24], 1'b1);
    send_checksum(1'b0);
    wait_end("glitch");
    n_checks++; if (wa_q.size() != 1) begin n_err++; $display("FAIL glitch_count: got %0d want 1", wa_q.size()); end
    if (wa_q.size() > 0) begin
      n_checks++; if (wd_q[0] !== w) begin n_err++; $display("FAIL glitch_data: got %h want %h", wd_q[0], w); end
    end
    n_checks++; if ({boot_done, boot_err} !== 2'b10) begin n_err++; $display("FAIL glitch_status: got %b want 10", {boot_done, boot_err}); end
  endtask

  task test_reset_mid;
    do_reset(2);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    do_reset(1);
    exp_words.delete();
    exp_words.push_back({8'($urandom), 8'($urandom), 16'h0000});
    send_image(16'd1);
    wait_end("rstmid");
    n_checks++; if (wa_q.size() != 1) begin n_err++; $display("FAIL rstmid_count: got %0d want 1", wa_q.size()); end
    if (wa_q.size() > 0) begin
      n_checks++; if (wa_q[0] !== '0) begin n_err++; $display("FAIL rstmid_addr: got %h want 0", wa_q[0]); end
      n_checks++; if (wd_q[0] !== exp_words[0]) begin n_err++; $display("FAIL rstmid_data: got %h want %h", wd_q[0], exp_words[0]); end
    end
  endtask

  task test_oversize;
    do_reset(2);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h10, 1'b1);
    wait_end("oversize");
    n_checks++; if (wa_q.size() != 0) begin n_err++; $display("FAIL oversize_count: got %0d want 0", wa_q.size()); end
    n_checks++; if ({core_rst_n, boot_done, boot_err} !== 3'b001) begin n_err++; $display("FAIL oversize_status: got %b want 001", {core_rst_n, boot_done, boot_err}); end
  endtask

  task test_bad_checksum;
`ifdef UART_LOADER_CHECKSUM_EN
    do_reset(2);
    exp_words.delete();
    exp_words.push_back($urandom);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_word(exp_words[0]);
    send_checksum(1'b1);
    wait_end("badsum");
    n_checks++; if (wa_q.size() != 1) begin n_err++; $display("FAIL badsum_count: got %0d want 1", wa_q.size()); end
    n_checks++; if ({core_rst_n, boot_done, boot_err} !== 3'b001) begin n_err++; $display("FAIL badsum_status: got %b want 001", {core_rst_n, boot_done, boot_err}); end
`else
    @(negedge clk);
`endif
  endtask

  initial begin
    test_reset;
    test_spec_image;
    test_junk_zero_len;
    test_random_images;
    test_framing_error;
    test_glitch;
    test_reset_mid;
    test_oversize;
    test_bad_checksum;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
